// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared data width, mux select codes and arbiter state encoding
package mux4_rr_arbiter_pkg;
  localparam int DW = 4;
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;
  typedef enum logic {IDLE, GNT} state_t;
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester bus (req, a..d) and arbiter outputs (grant, sel, busy, y_out, y_valid)
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;
  logic [3:0] req;
  logic [DW-1:0] a, b, c, d;
  logic [3:0] grant;
  logic [1:0] sel;
  logic busy;
  logic [DW-1:0] y_out;
  logic y_valid;
  modport master(output req, a, b, c, d, input grant, sel, busy, y_out, y_valid);
  modport slave(input req, a, b, c, d, output grant, sel, busy, y_out, y_valid);
endinterface

// File: rtl/mux4_rr_arbiter_mux.sv
// mux4_rr_arbiter_mux: combinational 4-to-1 mux; sel picks a/b/c/d onto y
module mux4_rr_arbiter_mux
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [1:0]    sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] y
);
  assign y = sel == S0 ? a : sel == S1 ? b : sel == S2 ? c : d;
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin, hold-bounded arbiter over a 4-to-1 mux; clk/rst plus slave bus (req,a..d in; grant,sel,busy,y_out,y_valid out)
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter logic [3:0] HOLD = 4'd4
) (
  input logic clk,
  input logic rst,
  mux4_rr_arbiter_if.slave bus
);
  state_t state;
  logic [1:0] ptr;
  logic [3:0] cnt;
  logic [DW-1:0] mux_y;
  logic rel;
  logic [1:0] base;
  logic [2:0] nxt;
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] i;
    pick = '0;
    for (int k = 3; k >= 0; k--) begin
      i = p + 2'(k);
      if (r[i]) pick = {1'b1, i};
    end
  endfunction
  assign rel  = state == GNT && (!bus.req[bus.sel] || cnt == HOLD - 4'd1);
  assign base = state == IDLE ? ptr : bus.sel + 2'd1;
  assign nxt  = pick(bus.req, base);
  mux4_rr_arbiter_mux u_mux (
    .sel(bus.sel),
    .a(bus.a),
    .b(bus.b),
    .c(bus.c),
    .d(bus.d),
    .y(mux_y)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      cnt         <= 4'd0;
      bus.grant   <= 4'd0;
      bus.sel     <= S0;
      bus.busy    <= 1'b0;
      bus.y_out   <= '0;
      bus.y_valid <= 1'b0;
    end else begin
      bus.y_valid <= bus.busy;
      if (bus.busy) bus.y_out <= mux_y;
      if (state == IDLE || rel) begin
        if (rel) ptr <= bus.sel + 2'd1;
        cnt       <= 4'd0;
        state     <= nxt[2] ? GNT : IDLE;
        bus.busy  <= nxt[2];
        bus.grant <= nxt[2] ? 4'b0001 << nxt[1:0] : 4'd0;
        if (nxt[2]) bus.sel <= nxt[1:0];
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: scoreboard bench comparing the arbiter against a round-robin reference model
module tb_mux4_rr_arbiter;
  localparam int HOLD = 2;
  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       sel_chk;
    logic       busy;
    logic [3:0] y;
    logic       yv;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  exp_t q[$];
  int owner = -1;
  int run = 0;
  int mptr = 0;
  logic [3:0] my = 4'd0;
  mux4_rr_arbiter_if bus();
  mux4_rr_arbiter #(.HOLD(4'(HOLD))) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    logic [3:0] dat [4];
    int base;
    dat[0] = bus.a;
    dat[1] = bus.b;
    dat[2] = bus.c;
    dat[3] = bus.d;
    e = '0;
    if (rst) begin
      owner = -1;
      run = 0;
      mptr = 0;
      my = 4'd0;
      e.sel_chk = 1'b1;
    end else begin
      e.yv = owner >= 0;
      if (owner >= 0) my = dat[owner];
      if (owner < 0 || !bus.req[owner] || run == HOLD) begin
        base = owner < 0 ? mptr : (owner + 1) % 4;
        if (owner >= 0) mptr = base;
        owner = -1;
        for (int k = 0; k < 4; k++)
          if (owner < 0 && bus.req[(base + k) % 4]) owner = (base + k) % 4;
        run = 1;
      end else begin
        run++;
      end
      e.sel = 2'(owner);
      e.sel_chk = owner >= 0;
    end
    e.grant = owner < 0 ? 4'd0 : 4'(1 << owner);
    e.busy = owner >= 0;
    e.y = my;
    q.push_back(e);
  end
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("grant", bus.grant, e.grant);
        if (e.sel_chk) chk("sel", {2'b00, bus.sel}, {2'b00, e.sel});
        chk("busy", {3'b000, bus.busy}, {3'b000, e.busy});
        chk("y_out", bus.y_out, e.y);
        chk("y_valid", {3'b000, bus.y_valid}, {3'b000, e.yv});
      end
    end
  end
  task automatic step(input logic r_st, input logic [3:0] r, input logic [3:0] av, input logic [3:0] bv,
                      input logic [3:0] cv, input logic [3:0] dv, input int n);
    repeat (n) begin
      @(negedge clk);
      rst = r_st;
      bus.req = r;
      bus.a = av;
      bus.b = bv;
      bus.c = cv;
      bus.d = dv;
    end
  endtask
  initial begin
    logic [3:0] r;
    bus.req = 4'd0;
    bus.a = 4'd0;
    bus.b = 4'd0;
    bus.c = 4'd0;
    bus.d = 4'd0;
    step(1'b1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    step(1'b0, 4'b0000, 4'h5, 4'h6, 4'h7, 4'h8, 10);
    step(1'b0, 4'b0100, 4'h1, 4'h2, 4'hA, 4'h4, 12);
    step(1'b0, 4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 3);
    step(1'b0, 4'b1111, 4'h1, 4'h2, 4'h3, 4'h4, 16);
    step(1'b0, 4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 3);
    step(1'b0, 4'b0010, 4'h9, 4'hB, 4'hC, 4'hD, 2);
    step(1'b0, 4'b0000, 4'h9, 4'hB, 4'hC, 4'hD, 3);
    step(1'b0, 4'b1111, 4'h9, 4'hB, 4'hC, 4'hD, 1);
    @(negedge clk);
    chk("search_from_2", bus.grant, 4'b0100);
    step(1'b0, 4'b0000, 4'h9, 4'hB, 4'hC, 4'hD, 3);
    step(1'b0, 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4, 1);
    step(1'b0, 4'b1001, 4'h1, 4'h2, 4'h3, 4'h4, 3);
    @(negedge clk);
    chk("ptr_wrap", bus.grant, 4'b0001);
    step(1'b0, 4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 3);
    step(1'b0, 4'b0010, 4'h1, 4'h7, 4'h3, 4'h4, 2);
    step(1'b1, 4'b0010, 4'h1, 4'h7, 4'h3, 4'h4, 1);
    @(negedge clk);
    chk("rst_grant", bus.grant, 4'b0000);
    chk("rst_y_valid", {3'b000, bus.y_valid}, 4'd0);
    step(1'b0, 4'b1010, 4'h1, 4'h7, 4'h3, 4'h4, 1);
    @(negedge clk);
    chk("post_rst_grant", bus.grant, 4'b0010);
    r = 4'd0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      step($urandom_range(0, 60) == 0, r, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1);
    end
    step(1'b0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
